// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared constants and types for the 32-by-16 sequential divider.
//   DVD_W  : dividend width
//   DVS_W  : divisor / quotient / remainder width
//   ITER   : number of restoring iterations (one quotient bit each)
//   CNT_W  : width of the iteration counter
//   div_state_e : controller states (idle, iterate, result held)
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int unsigned DVD_W = 32;
    localparam int unsigned DVS_W = 16;
    localparam int unsigned ITER  = 16;
    localparam int unsigned CNT_W = $clog2(ITER);

    // Partial remainder carries one guard bit above the divisor width.
    localparam int unsigned REM_W = DVS_W + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } div_state_e;

    // Quotient does not fit in DVS_W bits when the upper half of the dividend
    // already reaches the divisor.
    function automatic logic quot_overflow(input logic [DVD_W-1:0] dvd,
                                           input logic [DVS_W-1:0] dvs);
        return (dvs != '0) && (dvd[DVD_W-1:DVS_W] >= dvs);
    endfunction

endpackage

// File: rtl/sub_17b.sv
// -----------------------------------------------------------------------------
// sub_17b
// 17-bit ripple-borrow subtractor: diff = a - b.
//   a    : minuend
//   b    : subtrahend
//   diff : a - b modulo 2^17
//   neg  : borrow out of the MSB, i.e. a < b (result negative)
// -----------------------------------------------------------------------------
module sub_17b
    import div_pkg::*;
(
    input  logic [REM_W-1:0] a,
    input  logic [REM_W-1:0] b,
    output logic [REM_W-1:0] diff,
    output logic             neg
);

    logic [REM_W:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < REM_W; i++) begin : g_bit
        // Full subtractor cell: borrow when a < b + borrow_in for this bit.
        assign diff[i]     = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign neg = borrow[REM_W];

endmodule

// File: rtl/div_32by16_seq.sv
// -----------------------------------------------------------------------------
// div_32by16_seq
// Unsigned 32/16 restoring divider, one quotient bit per clock, MSB first.
// Valid/ready on both sides; results are registered and held until accepted.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : dividend/divisor presented
//   in_ready  : divider idle and able to accept an operation
//   dividend  : 32-bit unsigned numerator
//   divisor   : 16-bit unsigned denominator
//   out_valid : result presented
//   out_ready : consumer accepts result
//   quotient  : 16-bit quotient (all ones on divide-by-zero or overflow)
//   remainder : 16-bit remainder
//   div_zero  : divisor was zero
//   overflow  : quotient would not fit in 16 bits
// -----------------------------------------------------------------------------
module div_32by16_seq
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVS_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    div_state_e state_q, state_d;

    logic [CNT_W-1:0] iter_q, iter_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [DVS_W-1:0] sr_q, sr_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVS_W-1:0] quotient_q, quotient_d;
    logic [DVS_W-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             overflow_q, overflow_d;

    // {partial remainder, shift register} shifted left by one; the MSB of the
    // pair falls off since the partial remainder is always below the divisor.
    logic [REM_W+DVS_W-1:0] pair_shift;
    logic [REM_W-1:0]       rem_shift;
    logic [REM_W-1:0]       trial_diff;
    logic                   trial_neg;
    logic [REM_W-1:0]       rem_next;
    logic [DVS_W-1:0]       sr_next;

    assign pair_shift = {rem_q, sr_q} << 1;
    assign rem_shift  = pair_shift[REM_W+DVS_W-1:DVS_W];

    sub_17b u_trial_sub (
        .a    (rem_shift),
        .b    ({1'b0, dvs_q}),
        .diff (trial_diff),
        .neg  (trial_neg)
    );

    // Restore on a negative trial, otherwise keep the difference; the
    // quotient bit enters at the LSB vacated by the shift.
    assign rem_next = trial_neg ? rem_shift : trial_diff;
    assign sr_next  = pair_shift[DVS_W-1:0] | {{(DVS_W-1){1'b0}}, ~trial_neg};

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        rem_d       = rem_q;
        sr_d        = sr_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    if (divisor == '0) begin
                        state_d     = StDone;
                        div_zero_d  = 1'b1;
                        overflow_d  = 1'b0;
                        quotient_d  = '1;
                        remainder_d = dividend[DVS_W-1:0];
                    end else if (quot_overflow(dividend, divisor)) begin
                        state_d     = StDone;
                        div_zero_d  = 1'b0;
                        overflow_d  = 1'b1;
                        quotient_d  = '1;
                        remainder_d = '0;
                    end else begin
                        state_d    = StCalc;
                        div_zero_d = 1'b0;
                        overflow_d = 1'b0;
                        rem_d      = {1'b0, dividend[DVD_W-1:DVS_W]};
                        sr_d       = dividend[DVS_W-1:0];
                        iter_d     = CNT_W'(ITER - 1);
                    end
                end
            end

            StCalc: begin
                rem_d = rem_next;
                sr_d  = sr_next;
                if (iter_q == '0) begin
                    state_d     = StDone;
                    quotient_d  = sr_next;
                    remainder_d = rem_next[DVS_W-1:0];
                end else begin
                    iter_d = iter_q - 1'b1;
                end
            end

            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            iter_q      <= '0;
            rem_q       <= '0;
            sr_q        <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            rem_q       <= rem_d;
            sr_q        <= sr_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end

    // Handshake flags decode only the state register.
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

endmodule
